// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-access stage.
// Covers the control-bundle field map, access sizes, FSM states and the captured access descriptor.
package cpu_mem_pkg;

    // Control bundle: bits [7:5] belong to other stages and only pass through here.
    localparam int CON_MSB          = 7;
    localparam int CON_LSB          = 0;
    localparam int CON_MEM_READ     = 0;
    localparam int CON_MEM_WRITE    = 1;
    localparam int CON_MEM_SIZE_LSB = 2;
    localparam int CON_MEM_SIZE_MSB = 3;
    localparam int CON_MEM_SIGN     = 4;

    localparam logic [CON_MSB:CON_LSB] CON_NOP = '0;
    localparam logic REG_WRITE_EN_F = 1'b0;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        MEM_STATE_IDLE = 2'd0,
        MEM_STATE_REQ  = 2'd1,
        MEM_STATE_WAIT = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic      read;
        mem_size_e size;
        logic      sign;
        logic [1:0] off;
    } access_t;

endpackage

// File: rtl/cpu_mem_align.sv
// Byte-lane steering for the data-memory port.
// Computes store enables and replicated data, extends load lanes and flags misalignment.
module cpu_mem_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] lane;

    // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        lane       = rdata >> {off, 3'b000};
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = lane;
        misaligned = 1'b0;
        case (mem_size_e'(size))
            MEM_SIZE_BYTE: begin
                be        = 4'b0001 << off;
                wdata     = {4{store_data[7:0]}};
                load_data = sign ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
            end
            MEM_SIZE_HALF: begin
                be         = 4'b0011 << off;
                wdata      = {2{store_data[15:0]}};
                load_data  = sign ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
                misaligned = off[0];
            end
            default: begin
                misaligned = |off;
            end
        endcase
    end

endmodule

// File: rtl/cpu_mem.sv
// Memory-access pipeline stage: drives a valid/ready data-memory port, stalls upstream while an
// access is outstanding and registers the write-back fields.
module cpu_mem
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
)
(
    input  logic                     clk,
    input  logic                     clr,
    input  logic [31:0]              current_pc_ex,
    input  logic [31:0]              ins_ex,
    input  logic [CON_MSB:CON_LSB]   controls_ex,
    input  logic [31:0]              alu_result,
    input  logic [31:0]              reg_read2_data_ex,
    input  logic                     reg_write_en,
    input  logic [4:0]               reg_write_num,
    output logic                     stall,
    output logic                     mem_req,
    input  logic                     mem_req_ready,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_rsp_valid,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              current_pc_mem,
    output logic [31:0]              ins_mem,
    output logic [CON_MSB:CON_LSB]   controls_mem,
    output logic [31:0]              alu_result_mem,
    output logic [31:0]              mem_read_data,
    output logic                     reg_write_en_mem,
    output logic [4:0]               reg_write_num_mem,
    output logic                     mem_fault
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    mem_state_e  state, state_nxt;
    logic [TW-1:0] timer;
    access_t     acc_in, acc_q, acc_sel;
    logic        mem_op, misaligned;
    logic        start, finish, timeout, misaligned_fault, retire, fault_now;
    logic [3:0]  be;
    logic [31:0] wdata, load_data;

    assign mem_op      = controls_ex[CON_MEM_READ] | controls_ex[CON_MEM_WRITE];
    assign acc_in.read = controls_ex[CON_MEM_READ];
    assign acc_in.size = mem_size_e'(controls_ex[CON_MEM_SIZE_MSB:CON_MEM_SIZE_LSB]);
    assign acc_in.sign = controls_ex[CON_MEM_SIGN];
    assign acc_in.off  = alu_result[1:0];

    // Store lanes come from the EX fields at issue; the load lane uses what was captured then.
    assign acc_sel = (state == MEM_STATE_IDLE) ? acc_in : acc_q;

    cpu_mem_align u_align (
        .size       (acc_sel.size),
        .sign       (acc_sel.sign),
        .off        (acc_sel.off),
        .store_data (reg_read2_data_ex),
        .rdata      (mem_rdata),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    always_comb begin
        state_nxt        = state;
        stall            = 1'b0;
        start            = 1'b0;
        finish           = 1'b0;
        timeout          = 1'b0;
        misaligned_fault = 1'b0;
        case (state)
            MEM_STATE_IDLE: begin
                if (mem_op && misaligned) begin
                    misaligned_fault = 1'b1;
                end else if (mem_op) begin
                    stall     = 1'b1;
                    start     = 1'b1;
                    state_nxt = MEM_STATE_REQ;
                end
            end
            MEM_STATE_REQ: begin
                if (timer == TIMER_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = MEM_STATE_IDLE;
                end else begin
                    stall = 1'b1;
                    if (mem_req_ready) state_nxt = MEM_STATE_WAIT;
                end
            end
            MEM_STATE_WAIT: begin
                if (mem_rsp_valid) begin
                    finish    = 1'b1;
                    state_nxt = MEM_STATE_IDLE;
                end else if (timer == TIMER_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = MEM_STATE_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = MEM_STATE_IDLE;
        endcase
    end

    assign retire    = ((state == MEM_STATE_IDLE) && !start) || finish || timeout;
    assign fault_now = timeout | misaligned_fault;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= MEM_STATE_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= (state == MEM_STATE_IDLE) ? '0 : timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            mem_be            <= '0;
            acc_q             <= '0;
            current_pc_mem    <= '0;
            ins_mem           <= '0;
            controls_mem      <= CON_NOP;
            alu_result_mem    <= '0;
            mem_read_data     <= '0;
            reg_write_en_mem  <= REG_WRITE_EN_F;
            reg_write_num_mem <= '0;
            mem_fault         <= 1'b0;
        end else begin
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= controls_ex[CON_MEM_WRITE];
                mem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
                mem_wdata <= wdata;
                mem_be    <= be;
                acc_q     <= acc_in;
            end else if ((state == MEM_STATE_REQ) && (state_nxt != MEM_STATE_REQ)) begin
                mem_req <= 1'b0;
            end

            if (retire) begin
                current_pc_mem    <= current_pc_ex;
                ins_mem           <= ins_ex;
                controls_mem      <= controls_ex;
                alu_result_mem    <= alu_result;
                mem_read_data     <= (finish && acc_q.read) ? load_data : '0;
                reg_write_en_mem  <= reg_write_en & ~fault_now;
                reg_write_num_mem <= reg_write_num;
                mem_fault         <= fault_now;
            end else begin
                current_pc_mem    <= '0;
                ins_mem           <= '0;
                controls_mem      <= CON_NOP;
                alu_result_mem    <= '0;
                mem_read_data     <= '0;
                reg_write_en_mem  <= REG_WRITE_EN_F;
                reg_write_num_mem <= '0;
                mem_fault         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem.sv
// Directed bench for cpu_mem: expected write-back records are queued at issue and compared at retire,
// with the bench acting as the data memory.
module tb_cpu_mem;
    import cpu_mem_pkg::*;

    localparam int T = 16;

    logic                   clk = 1'b0;
    logic                   clr;
    logic [31:0]            current_pc_ex, ins_ex, alu_result, reg_read2_data_ex;
    logic [CON_MSB:CON_LSB] controls_ex;
    logic                   reg_write_en;
    logic [4:0]             reg_write_num;
    logic                   stall, mem_req, mem_req_ready, mem_we;
    logic [31:0]            mem_addr, mem_wdata, mem_rdata;
    logic [3:0]             mem_be;
    logic                   mem_rsp_valid;
    logic [31:0]            current_pc_mem, ins_mem, alu_result_mem, mem_read_data;
    logic [CON_MSB:CON_LSB] controls_mem;
    logic                   reg_write_en_mem;
    logic [4:0]             reg_write_num_mem;
    logic                   mem_fault;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]            pc;
        logic [31:0]            ins;
        logic [CON_MSB:CON_LSB] ctrl;
        logic [31:0]            alu;
        logic [31:0]            rd;
        logic                   wen;
        logic [4:0]             num;
        logic                   fault;
    } exp_t;

    exp_t sb[$];

    cpu_mem #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk               (clk),
        .clr               (clr),
        .current_pc_ex     (current_pc_ex),
        .ins_ex            (ins_ex),
        .controls_ex       (controls_ex),
        .alu_result        (alu_result),
        .reg_read2_data_ex (reg_read2_data_ex),
        .reg_write_en      (reg_write_en),
        .reg_write_num     (reg_write_num),
        .stall             (stall),
        .mem_req           (mem_req),
        .mem_req_ready     (mem_req_ready),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_be            (mem_be),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rdata         (mem_rdata),
        .current_pc_mem    (current_pc_mem),
        .ins_mem           (ins_mem),
        .controls_mem      (controls_mem),
        .alu_result_mem    (alu_result_mem),
        .mem_read_data     (mem_read_data),
        .reg_write_en_mem  (reg_write_en_mem),
        .reg_write_num_mem (reg_write_num_mem),
        .mem_fault         (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [CON_MSB:CON_LSB] ctl(input logic rd, input logic wr,
                                                   input mem_size_e size, input logic sgn);
        logic [CON_MSB:CON_LSB] c;
        c = '0;
        c[CON_MEM_READ]                      = rd;
        c[CON_MEM_WRITE]                     = wr;
        c[CON_MEM_SIZE_MSB:CON_MEM_SIZE_LSB] = size;
        c[CON_MEM_SIGN]                      = sgn;
        c[7]                                 = 1'b1;
        return c;
    endfunction

    task automatic drive_nop();
        current_pc_ex     = '0;
        ins_ex            = '0;
        controls_ex       = CON_NOP;
        alu_result        = '0;
        reg_read2_data_ex = '0;
        reg_write_en      = 1'b0;
        reg_write_num     = '0;
    endtask

    // Entered and left at posedge+1; plays memory with the given ready/response delays.
    task automatic run_op(input string name,
                          input logic [31:0] pc, input logic [31:0] ins,
                          input logic [CON_MSB:CON_LSB] ctrl, input logic [31:0] alu,
                          input logic [31:0] wd, input logic wen, input logic [4:0] num,
                          input int ready_wait, input int rsp_wait, input logic [31:0] rdata,
                          input logic [31:0] exp_rd, input logic exp_wen, input logic exp_fault,
                          input int exp_stalls, input logic exp_req, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_addr,
                          input logic exp_we);
        exp_t e, got;
        int stalls, req_cnt, wait_cnt;
        logic saw_req, in_wait, done, hs, req_now;
        logic [3:0]  cap_be;
        logic [31:0] cap_wdata, cap_addr;
        logic cap_we;

        current_pc_ex = pc; ins_ex = ins; controls_ex = ctrl; alu_result = alu;
        reg_read2_data_ex = wd; reg_write_en = wen; reg_write_num = num; mem_rdata = rdata;
        e = '{pc: pc, ins: ins, ctrl: ctrl, alu: alu, rd: exp_rd, wen: exp_wen, num: num, fault: exp_fault};
        sb.push_back(e);

        stalls = 0; req_cnt = 0; wait_cnt = 0; saw_req = 0; in_wait = 0; done = 0;
        cap_be = '0; cap_wdata = '0; cap_addr = '0; cap_we = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            req_now       = mem_req;
            mem_req_ready = req_now && (req_cnt >= ready_wait);
            mem_rsp_valid = in_wait && (wait_cnt >= rsp_wait);
            if (req_now && !saw_req) begin
                saw_req = 1'b1; cap_be = mem_be; cap_wdata = mem_wdata;
                cap_addr = mem_addr; cap_we = mem_we;
            end
            #3;
            hs = req_now && mem_req_ready;
            if (stall) stalls++; else done = 1'b1;
            @(posedge clk); #1;
            if (in_wait) wait_cnt++;
            if (hs) in_wait = 1'b1;
            if (req_now) req_cnt++;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;

        check({name, "_retired"}, 32'(done), 32'd1);
        check({name, "_stalls"}, stalls, exp_stalls);
        check({name, "_req_seen"}, 32'(saw_req), 32'(exp_req));
        if (exp_req) begin
            check({name, "_be"}, 32'(cap_be), 32'(exp_be));
            check({name, "_wdata"}, cap_wdata, exp_wdata);
            check({name, "_addr"}, cap_addr, exp_addr);
            check({name, "_we"}, 32'(cap_we), 32'(exp_we));
        end
        got = sb.pop_front();
        check({name, "_pc"}, current_pc_mem, got.pc);
        check({name, "_ins"}, ins_mem, got.ins);
        check({name, "_ctrl"}, 32'(controls_mem), 32'(got.ctrl));
        check({name, "_alu"}, alu_result_mem, got.alu);
        check({name, "_rdata"}, mem_read_data, got.rd);
        check({name, "_wen"}, 32'(reg_write_en_mem), 32'(got.wen));
        check({name, "_num"}, 32'(reg_write_num_mem), 32'(got.num));
        check({name, "_fault"}, 32'(mem_fault), 32'(got.fault));
        check({name, "_req_low"}, 32'(mem_req), 32'd0);
        drive_nop();
    endtask

    initial begin
        clr = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_ctrl", 32'(controls_mem), 32'(CON_NOP));
        check("rst_wen", 32'(reg_write_en_mem), 32'(REG_WRITE_EN_F));
        check("rst_fault", 32'(mem_fault), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        clr = 1'b1;
        @(posedge clk); #1;

        run_op("addu", 32'h400, 32'h00851021, 8'h80, 32'h1234, 32'h5555, 1'b1, 5'd2,
               0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        run_op("lw", 32'h404, 32'h8C0A0100, ctl(1, 0, MEM_SIZE_WORD, 0), 32'h100, 32'h11112222,
               1'b1, 5'd10, 0, 2, 32'hDEADBEEF,
               32'hDEADBEEF, 1'b1, 1'b0, 4, 1'b1, 4'b1111, 32'h11112222, 32'h100, 1'b0);
        run_op("lb", 32'h408, 32'h800B0103, ctl(1, 0, MEM_SIZE_BYTE, 1), 32'h103, 32'h77,
               1'b1, 5'd11, 0, 0, 32'h80FF0000,
               32'hFFFFFF80, 1'b1, 1'b0, 2, 1'b1, 4'b1000, 32'h77777777, 32'h100, 1'b0);
        run_op("lbu", 32'h40C, 32'h900B0103, ctl(1, 0, MEM_SIZE_BYTE, 0), 32'h103, 32'h77,
               1'b1, 5'd11, 0, 0, 32'h80FF0000,
               32'h00000080, 1'b1, 1'b0, 2, 1'b1, 4'b1000, 32'h77777777, 32'h100, 1'b0);
        run_op("sh", 32'h410, 32'hA40C0102, ctl(0, 1, MEM_SIZE_HALF, 0), 32'h102, 32'h0000ABCD,
               1'b0, 5'd0, 1, 1, 32'h12345678,
               32'h0, 1'b0, 1'b0, 4, 1'b1, 4'b1100, 32'hABCDABCD, 32'h100, 1'b1);
        run_op("lw_mis", 32'h414, 32'h8C0D0101, ctl(1, 0, MEM_SIZE_WORD, 0), 32'h101, 32'h0,
               1'b1, 5'd13, 0, 0, 32'h0,
               32'h0, 1'b0, 1'b1, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        check("fault_pulse_end", 32'(mem_fault), 32'd0);
        run_op("lh", 32'h418, 32'h840E0102, ctl(1, 0, MEM_SIZE_HALF, 1), 32'h102, 32'h99991357,
               1'b1, 5'd14, 0, 0, 32'h80015678,
               32'hFFFF8001, 1'b1, 1'b0, 2, 1'b1, 4'b1100, 32'h13571357, 32'h100, 1'b0);
        run_op("sb", 32'h41C, 32'hA00F0101, ctl(0, 1, MEM_SIZE_BYTE, 0), 32'h101, 32'h1234565A,
               1'b0, 5'd0, 0, 0, 32'h0,
               32'h0, 1'b0, 1'b0, 2, 1'b1, 4'b0010, 32'h5A5A5A5A, 32'h100, 1'b1);
        run_op("lh_mis", 32'h420, 32'h84100103, ctl(1, 0, MEM_SIZE_HALF, 1), 32'h103, 32'h0,
               1'b1, 5'd16, 0, 0, 32'h0,
               32'h0, 1'b0, 1'b1, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        run_op("timeout", 32'h424, 32'h8C110200, ctl(1, 0, MEM_SIZE_WORD, 0), 32'h200, 32'h0,
               1'b1, 5'd17, 1000, 0, 32'h0,
               32'h0, 1'b0, 1'b1, T, 1'b1, 4'b1111, 32'h0, 32'h200, 1'b0);
        @(posedge clk); #1;
        check("timeout_pulse_end", 32'(mem_fault), 32'd0);

        // Reset while waiting for a response, then a stray response afterwards.
        current_pc_ex = 32'h500; ins_ex = 32'h8C120300; controls_ex = ctl(1, 0, MEM_SIZE_WORD, 0);
        alu_result = 32'h300; reg_write_en = 1'b1; reg_write_num = 5'd18;
        @(posedge clk); #1;
        check("rstw_req_up", 32'(mem_req), 32'd1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check("rstw_wait_stall", 32'(stall), 32'd1);
        clr = 1'b0;
        drive_nop();
        #1;
        check("rstw_req", 32'(mem_req), 32'd0);
        check("rstw_stall", 32'(stall), 32'd0);
        check("rstw_be", 32'(mem_be), 32'd0);
        check("rstw_addr", mem_addr, 32'h0);
        check("rstw_ctrl", 32'(controls_mem), 32'(CON_NOP));
        check("rstw_wen", 32'(reg_write_en_mem), 32'd0);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        mem_rdata = 32'hFFFFFFFF;
        mem_rsp_valid = 1'b1;
        #3;
        check("late_rsp_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        check("late_rsp_rdata", mem_read_data, 32'h0);
        check("late_rsp_req", 32'(mem_req), 32'd0);
        check("late_rsp_fault", 32'(mem_fault), 32'd0);
        check("late_rsp_wen", 32'(reg_write_en_mem), 32'd0);

        run_op("addu2", 32'h504, 32'h01094821, 8'h80, 32'h0BEEF, 32'h0, 1'b1, 5'd9,
               0, 0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem.md
Name: cpu_mem

Overview:
Memory-access stage directly downstream of the execute stage. It consumes the EX pipeline register (ALU result as address, rt data as store data, controls, write-back fields), performs byte/half/word loads and stores over a valid/ready data-memory interface, stalls the upstream pipeline while an access is outstanding, and registers everything the write-back stage needs. Non-memory instructions pass through in one cycle.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before the access is abandoned with a fault
ADDR_W, 32, data-memory address width

Ports:
clk  in  1  global clock, rising edge
clr  in  1  asynchronous reset, ACTIVE-LOW (0 = reset)
current_pc_ex  in  32  PC of instruction in EX register
ins_ex  in  32  instruction word
controls_ex  in  CON_MSB:CON_LSB  control bundle (uses CON_MEM_READ, CON_MEM_WRITE, CON_MEM_SIZE, CON_MEM_SIGN)
alu_result  in  32  effective address / ALU value
reg_read2_data_ex  in  32  store data
reg_write_en  in  1  WB enable from EX
reg_write_num  in  5  WB register from EX
stall  out  1  hold EX/ID/IF registers this cycle
mem_req  out  1  request valid (registered)
mem_req_ready  in  1  memory accepts request
mem_we  out  1  1 = store
mem_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_rsp_valid  in  1  response/ack valid (one cycle)
mem_rdata  in  32  load data word
current_pc_mem, ins_mem, controls_mem, alu_result_mem  out  32/32/CON/32  latched pass-through
mem_read_data  out  32  extended load result
reg_write_en_mem  out  1  WB enable
reg_write_num_mem  out  5  WB register
mem_fault  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset (clr=0, async): state IDLE, timeout counter 0, mem_req 0, mem_we 0, mem_addr/wdata 0, mem_be 0, all *_mem outputs 0, controls_mem CON_NOP, ins_mem 0, mem_read_data 0, reg_write_en_mem REG_WRITE_EN_F, mem_fault 0. Reset mid-access drops mem_req immediately; a late mem_rsp_valid after reset is ignored in IDLE.
- mem_op = CON_MEM_READ | CON_MEM_WRITE. Alignment: HALF needs addr[0]=0, WORD needs addr[1:0]=0, BYTE always aligned.
- IDLE, non-mem op: stall=0; output register loads inputs at next edge (latency 1).
- IDLE, misaligned mem op: no request; stall=0; register inputs with reg_write_en_mem=0, mem_fault=1 for that cycle.
- IDLE, aligned mem op: stall=1 (combinational); at edge -> REQ, mem_req=1, address/data/be/we registered; output register loads bubble (CON_NOP, reg_write_en_mem=0).
- REQ: stall=1; mem_req held stable until mem_req_ready=1 at an edge -> WAIT, mem_req=0. Bubble continues.
- WAIT: stall = !mem_rsp_valid. On mem_rsp_valid: latch instruction fields and mem_read_data, state -> IDLE; upstream advances on same edge. Stores also wait for mem_rsp_valid (write ack); mem_read_data=0 for stores.
- Minimum memory-op latency 3 cycles (ready and response each immediate).
- Timeout: counter increments each cycle in REQ/WAIT, clears in IDLE; reaching TIMEOUT_CYCLES -> IDLE, mem_req=0, stall=0, instruction retired with reg_write_en_mem=0, mem_fault=1.
- Stores: mem_be = 0001<<off (BYTE), 0011<<off (HALF), 1111 (WORD); mem_wdata = byte replicated x4 / half replicated x2 / word.
- Loads: lane = mem_rdata >> (8*off); BYTE/HALF sign-extended when CON_MEM_SIGN=1 else zero-extended.
- mem_rsp_valid outside WAIT ignored.

Decomposition:
- defines.vh: CON_MEM_READ, CON_MEM_WRITE, CON_MEM_SIZE, CON_MEM_SIGN field ranges; MEM_SIZE_BYTE/HALF/WORD; MEM_STATE_IDLE/REQ/WAIT encodings.
- Sub-module mem_align (combinational): size, sign, offset, store data, rdata -> be, wdata, extended load, misaligned flag.

Test Plan:
- addu passes through (alu_result=0x1234) -> stall never 1, alu_result_mem=0x1234 one edge later, mem_req stays 0.
- lw addr 0x100, ready=1, rsp after 2 cycles rdata=0xDEADBEEF -> stall 4 cycles, mem_be=1111, mem_read_data=0xDEADBEEF, reg_write_en_mem=1.
- lb addr 0x103 rdata=0x80FF0000 signed -> 0xFFFFFF80; lbu -> 0x00000080; mem_addr=0x100.
- sh addr 0x102 data 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; completes on ack.
- lw addr 0x101 -> no mem_req, mem_fault pulse, reg_write_en_mem=0, stall 0.
- ready held 0 for TIMEOUT_CYCLES -> mem_fault pulse, return IDLE; clr=0 during WAIT -> all outputs reset, rsp next cycle ignored.
